// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle synchronous instruction memory: owns the PC,
// issues word reads, buffers {instr, pc} in a small FIFO and hands them to decode.
//
// state  | meaning
// S_RUN  | reads issued whenever the FIFO has room for the returning word
// S_HALT | no new reads; a word already in flight is still captured
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        busy
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          room;
  logic          push;
  logic          pop;
  logic          full;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count == CW'(DEPTH));
  // a redirect in the return cycle squashes the word from the earlier read
  assign push      = inflight & ~redirect_valid;

  // occupancy once this edge's pop and pending capture settle; an issue now lands next edge
  assign occ  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign room = (occ < (CW+1)'(DEPTH));

  assign imem_addr = pc;
  assign busy      = inflight | out_valid;
  assign out_instr = out_valid ? mem_instr[rd_ptr] : NOP;
  assign out_pc    = out_valid ? mem_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // halt_req also gates issue directly so no read starts in the cycle it rises
  always_comb begin
    state_nxt = state;
    imem_en   = 1'b0;
    case (state)
      S_RUN: begin
        imem_en = ~halt_req & ~redirect_valid & room;
        if (halt_req) state_nxt = S_HALT;
      end
      S_HALT: begin
        if (!halt_req) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
      if (redirect_valid) begin
        pc     <= redirect_pc & 32'hFFFF_FFFC;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= inflight_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && full));

endmodule
